// File: rtl/pc_unit.sv
// pc_unit: 6502-style program counter with byte/word loads, increment and
// relative branches that fix up PCH in a second cycle on page crossing.
module pc_unit #(
  parameter int DATA_WIDTH = 8,
  parameter logic [2*DATA_WIDTH-1:0] RESET_PC = 16'hFFFC
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold,
  input  logic                    pc_inc,
  input  logic                    load_lo,
  input  logic                    load_hi,
  input  logic                    load_full,
  input  logic [DATA_WIDTH-1:0]   db_in,
  input  logic [2*DATA_WIDTH-1:0] abus_in,
  input  logic                    branch_take,
  input  logic [DATA_WIDTH-1:0]   branch_off,
  output logic [2*DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0]   pcl_out,
  output logic [DATA_WIDTH-1:0]   pch_out,
  output logic                    busy,
  output logic                    page_cross,
  output logic                    wrap
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE2 = {{(2*W-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, FIXUP} state_t;
  state_t state_q, state_d;
  logic [W-1:0] pcl_q, pcl_d, pch_q, pch_d;
  logic dir_q, dir_d, page_cross_q, page_cross_d, wrap_q, wrap_d;
  logic [W:0] br_sum;
  assign br_sum = {1'b0, pcl_q} + {1'b0, branch_off};
  // dir_q=1 means the pending fixup decrements PCH
  always_comb begin
    pcl_d = pcl_q;
    pch_d = pch_q;
    state_d = state_q;
    dir_d = dir_q;
    page_cross_d = 1'b0;
    wrap_d = 1'b0;
    if (!hold) begin
      if (state_q == FIXUP) begin
        pch_d = dir_q ? pch_q - ONE : pch_q + ONE;
        page_cross_d = 1'b1;
        wrap_d = dir_q ? (pch_q == '0) : (&pch_q);
        state_d = IDLE;
      end else if (load_full) begin
        {pch_d, pcl_d} = abus_in;
      end else if (load_lo || load_hi) begin
        pcl_d = load_lo ? db_in : pcl_q;
        pch_d = load_hi ? db_in : pch_q;
      end else if (branch_take) begin
        pcl_d = br_sum[W-1:0];
        dir_d = branch_off[W-1];
        state_d = (branch_off[W-1] ^ br_sum[W]) ? FIXUP : IDLE;
      end else if (pc_inc) begin
        {pch_d, pcl_d} = {pch_q, pcl_q} + ONE2;
        wrap_d = &{pch_q, pcl_q};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {pch_q, pcl_q} <= RESET_PC;
      state_q <= IDLE;
      dir_q <= 1'b0;
      page_cross_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pcl_q <= pcl_d;
      pch_q <= pch_d;
      state_q <= state_d;
      dir_q <= dir_d;
      page_cross_q <= page_cross_d;
      wrap_q <= wrap_d;
    end
  end
  assign pc_out = {pch_q, pcl_q};
  assign pcl_out = pcl_q;
  assign pch_out = pch_q;
  assign busy = (state_q == FIXUP);
  assign page_cross = page_cross_q;
  assign wrap = wrap_q;
endmodule
